// File: rtl/pwm_bank.sv
// pwm_bank: NumChannels-wide PWM peripheral on the device bus with double-buffered
// period/duty registers that only take effect at a period boundary.
module pwm_bank #(
   parameter int NumChannels = 4,
   parameter int CtrWidth    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   device_req_i,
   input  logic [31:0]            device_addr_i,
   input  logic                   device_we_i,
   input  logic [3:0]             device_be_i,
   input  logic [31:0]            device_wdata_i,
   output logic                   device_rvalid_o,
   output logic [31:0]            device_rdata_o,
   output logic [NumChannels-1:0] pwm_o
);
   logic [7:0]  w_ch;
   logic [1:0]  w_reg;
   logic [31:0] w_bmask;
   logic [31:0] w_rd;
   logic        w_wr;
   logic        w_unused;
   logic [NumChannels-1:0]               w_en;
   logic [NumChannels-1:0]               w_inv;
   logic [NumChannels-1:0][CtrWidth-1:0] w_p;
   logic [NumChannels-1:0][CtrWidth-1:0] w_d;
   logic [NumChannels-1:0][CtrWidth-1:0] w_cnt;
   logic        r_rvalid;
   logic [31:0] r_rdata;

   assign w_ch     = device_addr_i[11:4];
   assign w_reg    = device_addr_i[3:2];
   assign w_wr     = device_req_i & device_we_i;
   assign w_bmask  = {{8{device_be_i[3]}}, {8{device_be_i[2]}}, {8{device_be_i[1]}}, {8{device_be_i[0]}}};
   assign w_unused = ^{device_addr_i[31:12], device_addr_i[1:0]};

   // Out-of-range channel indices fall through with w_rd = 0
   always_comb begin
      w_rd = '0;
      for (int n = 0; n < NumChannels; n++)
         if (w_ch == 8'(n))
            w_rd = w_reg == 2'd0 ? {30'd0, w_inv[n], w_en[n]} :
                   w_reg == 2'd1 ? 32'(w_p[n]) :
                   w_reg == 2'd2 ? 32'(w_d[n]) : 32'(w_cnt[n]);
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= device_req_i;
         r_rdata  <= (device_req_i && !device_we_i) ? w_rd : '0;
      end

   assign device_rvalid_o = r_rvalid;
   assign device_rdata_o  = r_rdata;

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      logic                r_en;
      logic                r_inv;
      logic                r_pwm;
      logic [CtrWidth-1:0] r_p;
      logic [CtrWidth-1:0] r_d;
      logic [CtrWidth-1:0] r_pa;
      logic [CtrWidth-1:0] r_da;
      logic [CtrWidth-1:0] r_cnt;
      logic                w_hit;
      logic                w_load;
      logic [CtrWidth-1:0] w_p_new;
      logic [CtrWidth-1:0] w_d_new;

      assign w_hit   = w_wr && w_ch == 8'(c);
      // Active copies reload while idle and at every wrap
      assign w_load  = !r_en || r_cnt == r_pa;
      assign w_p_new = CtrWidth'((32'(r_p) & ~w_bmask) | (device_wdata_i & w_bmask));
      assign w_d_new = CtrWidth'((32'(r_d) & ~w_bmask) | (device_wdata_i & w_bmask));

      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) begin
            r_en  <= 1'b0;
            r_inv <= 1'b0;
            r_pwm <= 1'b0;
            r_p   <= '0;
            r_d   <= '0;
            r_pa  <= '0;
            r_da  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_hit && w_reg == 2'd0 && device_be_i[0]) begin
               r_en  <= device_wdata_i[0];
               r_inv <= device_wdata_i[1];
            end
            if (w_hit && w_reg == 2'd1) r_p <= w_p_new;
            if (w_hit && w_reg == 2'd2) r_d <= w_d_new;
            if (w_load) begin
               r_pa <= r_p;
               r_da <= r_d;
            end
            r_cnt <= w_load ? '0 : r_cnt + CtrWidth'(1);
            r_pwm <= r_en ? (r_cnt < r_da) ^ r_inv : r_inv;
         end

      assign w_en[c]  = r_en;
      assign w_inv[c] = r_inv;
      assign w_p[c]   = r_p;
      assign w_d[c]   = r_d;
      assign w_cnt[c] = r_cnt;
      assign pwm_o[c] = r_pwm;
   end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed bench for pwm_bank; bus responses are scored against a queue
// of expected read data filled as each request is driven.
module tb_pwm_bank;
   localparam int NumChannels = 4;
   localparam int CtrWidth    = 16;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b1;
   logic                   req = 1'b0;
   logic                   we = 1'b0;
   logic [31:0]            addr = '0;
   logic [3:0]             be = '0;
   logic [31:0]            wdata = '0;
   logic                   rvalid;
   logic [31:0]            rdata;
   logic [NumChannels-1:0] pwm;
   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        chk;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;
   exp_t q[$];
   exp_t m;

   pwm_bank #(.NumChannels(NumChannels), .CtrWidth(CtrWidth)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .device_req_i(req), .device_addr_i(addr),
      .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
      .device_rvalid_o(rvalid), .device_rdata_o(rdata), .pwm_o(pwm)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_i)
      if (rvalid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rvalid_extra: observed rvalid with no request pending");
         end else begin
            m = q.pop_front();
            if (m.chk) check($sformatf("rdata@%0h", m.a), rdata, m.d);
         end
      end

   task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] e);
      exp_t x;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      x.chk = !w; x.a = a; x.d = e;
      q.push_back(x);
      @(negedge clk_i);
      req = 1'b0; we = 1'b0;
      check($sformatf("rvalid@%0h", a), 32'(rvalid), 32'(1));
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus(1'b1, a, 4'hf, d, '0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e);
      bus(1'b0, a, 4'h0, '0, e);
   endtask

   task automatic hold(input int ch, input logic v, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         check(tag, 32'(pwm[ch]), 32'(v));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      #2 rst_ni = 1'b0;
      #1;
      check("rst_pwm", 32'(pwm), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", rdata, 0);
      idle(2);
      rst_ni = 1'b1;
      idle(1);
      for (int c = 0; c < NumChannels; c++)
         for (int r = 0; r < 4; r++) rd(32'(c * 16 + r * 4), 0);
      rd(32'h40, 0);
      check("rst_pwm_after", 32'(pwm), 0);
      // ch0: P=9 D=3 -> 3 high / 7 low
      wr(32'h04, 9); wr(32'h08, 3); wr(32'h00, 1);
      for (int j = 0; j < 30; j++) begin
         @(negedge clk_i);
         check($sformatf("ch0_pwm_%0d", j), 32'(pwm[0]), 32'((j % 10) < 3));
      end
      for (int i = 0; i < 12; i++) rd(32'h0C, 32'(i % 10));
      // ch1: duty rewritten mid-period only applies after the wrap
      wr(32'h14, 9); wr(32'h18, 3); wr(32'h10, 1);
      for (int j = 0; j < 20; j++) begin
         if (j == 4) wr(32'h18, 7);
         else @(negedge clk_i);
         check($sformatf("ch1_pwm_%0d", j), 32'(pwm[1]), 32'(j < 10 ? j < 3 : (j - 10) < 7));
      end
      // ch2 edge duties
      wr(32'h24, 9); wr(32'h28, 0); wr(32'h20, 1);
      hold(2, 1'b0, 25, "ch2_d0");
      wr(32'h28, 10);
      idle(12);
      hold(2, 1'b1, 20, "ch2_dfull");
      wr(32'h28, 0); wr(32'h20, 3);
      idle(12);
      hold(2, 1'b1, 20, "ch2_inv_d0");
      wr(32'h20, 0); wr(32'h24, 0); wr(32'h28, 1); wr(32'h20, 1);
      idle(2);
      hold(2, 1'b1, 15, "ch2_p0");
      rd(32'h2C, 0);
      // ch3 byte enables and register widths
      bus(1'b1, 32'h34, 4'b0010, 32'h0000_AB00, '0);
      rd(32'h34, 32'h0000_AB00);
      bus(1'b1, 32'h34, 4'b0001, 32'hFFFF_FF77, '0);
      rd(32'h34, 32'h0000_AB77);
      wr(32'h38, 32'hFFFF_FFFF);
      rd(32'h38, 32'h0000_FFFF);
      wr(32'h3C, 32'h55);
      rd(32'h3C, 0);
      wr(32'h30, 32'hFFFF_FFFF);
      rd(32'h30, 3);
      wr(32'h40, 32'hFFFF_FFFF);
      rd(32'h40, 0);
      rd(32'h7C, 0);
      // ch0 P=9 D=8: clearing EN with counter at 6
      wr(32'h00, 0); wr(32'h08, 8); wr(32'h00, 1);
      idle(5);
      wr(32'h00, 0);
      check("clr_pwm_before", 32'(pwm[0]), 1);
      rd(32'h0C, 6);
      check("clr_pwm_inv", 32'(pwm[0]), 0);
      rd(32'h0C, 0);
      // ch0 asynchronous reset mid-period
      wr(32'h00, 1);
      idle(6);
      rd(32'h04, 9);
      check("arst_pwm_before", 32'(pwm[0]), 1);
      #1 rst_ni = 1'b0;
      #1;
      check("arst_pwm", 32'(pwm), 0);
      check("arst_rvalid", 32'(rvalid), 0);
      check("arst_rdata", rdata, 0);
      @(negedge clk_i);
      idle(1);
      rst_ni = 1'b1;
      rd(32'h00, 0); rd(32'h04, 0); rd(32'h0C, 0); rd(32'h14, 0); rd(32'h34, 0);
      hold(0, 1'b0, 4, "arst_ch0_idle");
      check("arst_pwm_all", 32'(pwm), 0);
      idle(2);
      check("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
